// File: rtl/quiz_arbiter_n.sv
// N-player quiz responder: first-press arbitration, BCD answer countdown, foul lockout.
// Latency: 3 cycles from an input pin change to state/outputs (2 sync + 1 edge register).
// No backpressure: keys and Start are level inputs, outputs are registered levels and pulses.
module quiz_arbiter_n #(
    parameter int N_PLAYERS   = 4,
    parameter int TICK_CYCLES = 50_000_000,
    parameter int ANSWER_TIME = 30,
    parameter int ID_W        = 4
) (
    input  logic                 CLK,
    input  logic                 RSTn,
    input  logic                 Start,
    input  logic [N_PLAYERS-1:0] Key_In,
    output logic [N_PLAYERS-1:0] Winner_OneHot,
    output logic [ID_W-1:0]      Winner_Id,
    output logic [N_PLAYERS-1:0] Foul_OneHot,
    output logic                 Foul_Flag,
    output logic [3:0]           TimerH,
    output logic [3:0]           TimerL,
    output logic                 Time_Over,
    output logic                 Buzzer_Answer,
    output logic                 Buzzer_TimeOver,
    output logic [1:0]           State_Out
);

    localparam int              PW        = $clog2(TICK_CYCLES);
    localparam logic [PW-1:0]   PRESC_MAX = PW'(TICK_CYCLES - 1);
    localparam logic [3:0]      INIT_H    = 4'(ANSWER_TIME / 10);
    localparam logic [3:0]      INIT_L    = 4'(ANSWER_TIME % 10);

    typedef enum logic [1:0] {
        S_IDLE    = 2'b00,
        S_ARMED   = 2'b01,
        S_ANSWER  = 2'b10,
        S_TIMEOUT = 2'b11
    } state_t;

    // synchroniser chains; stage 3 is the previous-value register for edge detection
    logic [N_PLAYERS-1:0] key_s1_q, key_s2_q, key_s3_q;
    logic                 start_s1_q, start_s2_q, start_s3_q;

    state_t               state_q, state_d;
    logic [N_PLAYERS-1:0] win_oh_q, win_oh_d;
    logic [ID_W-1:0]      win_id_q, win_id_d;
    logic [N_PLAYERS-1:0] foul_q, foul_d;
    logic [3:0]           tmr_h_q, tmr_h_d;
    logic [3:0]           tmr_l_q, tmr_l_d;
    logic                 time_over_q, time_over_d;
    logic                 buz_ans_q, buz_ans_d;
    logic                 buz_to_q, buz_to_d;
    logic [PW-1:0]        presc_q, presc_d;

    logic [N_PLAYERS-1:0] press, valid, low_oh;
    logic [ID_W-1:0]      low_id;
    logic                 start_rise, start_fall;
    logic [3:0]           dec_h, dec_l;

    // Keys idle high (active-low), Start idles low; async inputs sampled through 2 flops
    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            key_s1_q   <= '1;
            key_s2_q   <= '1;
            key_s3_q   <= '1;
            start_s1_q <= 1'b0;
            start_s2_q <= 1'b0;
            start_s3_q <= 1'b0;
        end else begin
            key_s1_q   <= Key_In;
            key_s2_q   <= key_s1_q;
            key_s3_q   <= key_s2_q;
            start_s1_q <= Start;
            start_s2_q <= start_s1_q;
            start_s3_q <= start_s2_q;
        end
    end

    // Edge detection, lockout filtering, lowest-index priority and BCD borrow
    always_comb begin
        press      = key_s3_q & ~key_s2_q;
        start_rise = start_s2_q & ~start_s3_q;
        start_fall = start_s3_q & ~start_s2_q;
        valid      = press & ~foul_q;
        low_oh     = valid & (~valid + N_PLAYERS'(1));
        low_id     = '0;
        for (int i = N_PLAYERS - 1; i >= 0; i--) begin
            if (valid[i]) low_id = ID_W'(i + 1);
        end
        if (tmr_l_q == 4'd0) begin
            dec_l = 4'd9;
            dec_h = tmr_h_q - 4'd1;
        end else begin
            dec_l = tmr_l_q - 4'd1;
            dec_h = tmr_h_q;
        end
    end

    // Round FSM: next state and all registered outputs
    always_comb begin
        state_d     = state_q;
        win_oh_d    = win_oh_q;
        win_id_d    = win_id_q;
        foul_d      = foul_q;
        tmr_h_d     = tmr_h_q;
        tmr_l_d     = tmr_l_q;
        time_over_d = time_over_q;
        buz_ans_d   = 1'b0;
        buz_to_d    = 1'b0;
        presc_d     = presc_q;

        if (state_q != S_IDLE && start_fall) begin
            // round closed: discard everything, including any same-cycle press or tick
            state_d     = S_IDLE;
            win_oh_d    = '0;
            win_id_d    = '0;
            foul_d      = '0;
            time_over_d = 1'b0;
            presc_d     = '0;
            tmr_h_d     = INIT_H;
            tmr_l_d     = INIT_L;
        end else begin
            case (state_q)
                S_IDLE: begin
                    foul_d = foul_q | press;
                    if (start_rise) state_d = S_ARMED;
                end
                S_ARMED: begin
                    if (|valid) begin
                        state_d   = S_ANSWER;
                        win_oh_d  = low_oh;
                        win_id_d  = low_id;
                        buz_ans_d = 1'b1;
                        presc_d   = '0;
                    end
                end
                S_ANSWER: begin
                    if (presc_q == PRESC_MAX) begin
                        presc_d = '0;
                        tmr_h_d = dec_h;
                        tmr_l_d = dec_l;
                        if (dec_h == 4'd0 && dec_l == 4'd0) begin
                            state_d     = S_TIMEOUT;
                            time_over_d = 1'b1;
                            buz_to_d    = 1'b1;
                        end
                    end else begin
                        presc_d = presc_q + PW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    // State and output registers; reset abandons any round silently
    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            state_q     <= S_IDLE;
            win_oh_q    <= '0;
            win_id_q    <= '0;
            foul_q      <= '0;
            tmr_h_q     <= INIT_H;
            tmr_l_q     <= INIT_L;
            time_over_q <= 1'b0;
            buz_ans_q   <= 1'b0;
            buz_to_q    <= 1'b0;
            presc_q     <= '0;
        end else begin
            state_q     <= state_d;
            win_oh_q    <= win_oh_d;
            win_id_q    <= win_id_d;
            foul_q      <= foul_d;
            tmr_h_q     <= tmr_h_d;
            tmr_l_q     <= tmr_l_d;
            time_over_q <= time_over_d;
            buz_ans_q   <= buz_ans_d;
            buz_to_q    <= buz_to_d;
            presc_q     <= presc_d;
        end
    end

    assign Winner_OneHot   = win_oh_q;
    assign Winner_Id       = win_id_q;
    assign Foul_OneHot     = foul_q;
    assign Foul_Flag       = |foul_q;
    assign TimerH          = tmr_h_q;
    assign TimerL          = tmr_l_q;
    assign Time_Over       = time_over_q;
    assign Buzzer_Answer   = buz_ans_q;
    assign Buzzer_TimeOver = buz_to_q;
    assign State_Out       = state_q;

endmodule

// File: tb/tb_quiz_arbiter_n.sv
// Directed bench for quiz_arbiter_n: a 4-player/3 s instance and an 8-player/10 s instance.
// Inputs change and outputs are sampled 1 ns after each rising clock edge.
// Fixed cycle counts throughout; the run always ends on its own.
module tb_quiz_arbiter_n;

    logic       clk;
    logic       rst_n;

    logic       start_a;
    logic [3:0] key_a;
    logic [3:0] win_oh_a, foul_a;
    logic [3:0] win_id_a, tmr_h_a, tmr_l_a;
    logic       foul_flag_a, time_over_a, buz_ans_a, buz_to_a;
    logic [1:0] state_a;

    logic       start_b;
    logic [7:0] key_b;
    logic [7:0] win_oh_b, foul_b;
    logic [3:0] win_id_b, tmr_h_b, tmr_l_b;
    logic       foul_flag_b, time_over_b, buz_ans_b, buz_to_b;
    logic [1:0] state_b;

    int n_pass  = 0;
    int n_total = 0;

    quiz_arbiter_n #(.N_PLAYERS(4), .TICK_CYCLES(10), .ANSWER_TIME(3), .ID_W(4)) dut_a (
        .CLK(clk), .RSTn(rst_n), .Start(start_a), .Key_In(key_a),
        .Winner_OneHot(win_oh_a), .Winner_Id(win_id_a), .Foul_OneHot(foul_a),
        .Foul_Flag(foul_flag_a), .TimerH(tmr_h_a), .TimerL(tmr_l_a),
        .Time_Over(time_over_a), .Buzzer_Answer(buz_ans_a),
        .Buzzer_TimeOver(buz_to_a), .State_Out(state_a)
    );

    quiz_arbiter_n #(.N_PLAYERS(8), .TICK_CYCLES(10), .ANSWER_TIME(10), .ID_W(4)) dut_b (
        .CLK(clk), .RSTn(rst_n), .Start(start_b), .Key_In(key_b),
        .Winner_OneHot(win_oh_b), .Winner_Id(win_id_b), .Foul_OneHot(foul_b),
        .Foul_Flag(foul_flag_b), .TimerH(tmr_h_b), .TimerL(tmr_l_b),
        .Time_Over(time_over_b), .Buzzer_Answer(buz_ans_b),
        .Buzzer_TimeOver(buz_to_b), .State_Out(state_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total = n_total + 1;
        assert (obs === exp) n_pass = n_pass + 1;
        else $error("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    endtask

    initial begin
        rst_n   = 1'b0;
        start_a = 1'b0;
        key_a   = 4'hF;
        start_b = 1'b0;
        key_b   = 8'hFF;
        #23;

        // reset state
        chk("rst_state",  state_a, 2'b00);
        chk("rst_tmr_h",  tmr_h_a, 4'd0);
        chk("rst_tmr_l",  tmr_l_a, 4'd3);
        chk("rst_win",    win_oh_a, 4'b0000);
        chk("rst_id",     win_id_a, 4'd0);
        chk("rst_tover",  time_over_a, 1'b0);
        chk("rst_foul",   foul_flag_a, 1'b0);
        chk("rst_b_tmr",  {tmr_h_b, tmr_l_b}, 8'h10);
        rst_n = 1'b1;
        tick(2);

        // 1: key2 wins, countdown 03 -> 00, timeout
        start_a = 1'b1;
        tick(3);
        chk("t1_armed", state_a, 2'b01);
        key_a = 4'b1011;
        tick(2);
        chk("t1_latency", state_a, 2'b01);
        tick(1);
        chk("t1_state",  state_a, 2'b10);
        chk("t1_oh",     win_oh_a, 4'b0100);
        chk("t1_id",     win_id_a, 4'd3);
        chk("t1_buz_on", buz_ans_a, 1'b1);
        chk("t1_tmr03",  {tmr_h_a, tmr_l_a}, 8'h03);
        tick(1);
        key_a = 4'hF;
        chk("t1_buz_off", buz_ans_a, 1'b0);
        tick(8);
        chk("t1_pre_tick", {tmr_h_a, tmr_l_a}, 8'h03);
        tick(1);
        chk("t1_tmr02", {tmr_h_a, tmr_l_a}, 8'h02);
        tick(10);
        chk("t1_tmr01", {tmr_h_a, tmr_l_a}, 8'h01);
        tick(9);
        chk("t1_pre_to",  state_a, 2'b10);
        chk("t1_no_to",   buz_to_a, 1'b0);
        tick(1);
        chk("t1_tmr00",   {tmr_h_a, tmr_l_a}, 8'h00);
        chk("t1_timeout", state_a, 2'b11);
        chk("t1_tover",   time_over_a, 1'b1);
        chk("t1_buz_to",  buz_to_a, 1'b1);
        tick(1);
        chk("t1_buz_to_off", buz_to_a, 1'b0);
        chk("t1_tover_hold", time_over_a, 1'b1);
        chk("t1_win_hold",   win_id_a, 4'd3);
        start_a = 1'b0;
        tick(3);
        chk("t1_idle",     state_a, 2'b00);
        chk("t1_idle_tmr", {tmr_h_a, tmr_l_a}, 8'h03);
        chk("t1_idle_id",  win_id_a, 4'd0);
        chk("t1_idle_to",  time_over_a, 1'b0);

        // 2: keys 1 and 3 together, lower index wins
        start_a = 1'b1;
        tick(3);
        key_a = 4'b0101;
        tick(3);
        chk("t2_state", state_a, 2'b10);
        chk("t2_oh",    win_oh_a, 4'b0010);
        chk("t2_id",    win_id_a, 4'd2);
        key_a   = 4'hF;
        start_a = 1'b0;
        tick(3);
        chk("t2_idle", state_a, 2'b00);

        // 3: early press is a foul and locks player 0 out
        key_a = 4'b1110;
        tick(3);
        chk("t3_foul",      foul_a, 4'b0001);
        chk("t3_foul_flag", foul_flag_a, 1'b1);
        chk("t3_idle",      state_a, 2'b00);
        key_a = 4'hF;
        tick(1);
        start_a = 1'b1;
        tick(3);
        chk("t3_armed",     state_a, 2'b01);
        chk("t3_foul_keep", foul_a, 4'b0001);
        key_a = 4'b1110;
        tick(3);
        chk("t3_locked", state_a, 2'b01);
        key_a = 4'hF;
        tick(1);
        key_a = 4'b1101;
        tick(3);
        chk("t3_state", state_a, 2'b10);
        chk("t3_id",    win_id_a, 4'd2);
        chk("t3_oh",    win_oh_a, 4'b0010);
        key_a   = 4'hF;
        start_a = 1'b0;
        tick(3);
        chk("t3_foul_clr", foul_a, 4'b0000);

        // 4: everyone fouled, round cannot be won
        key_a = 4'b0000;
        tick(3);
        chk("t4_foul_all", foul_a, 4'b1111);
        key_a = 4'hF;
        start_a = 1'b1;
        tick(3);
        chk("t4_armed", state_a, 2'b01);
        key_a = 4'b1011;
        tick(5);
        chk("t4_stuck", state_a, 2'b01);
        chk("t4_no_buz", buz_ans_a, 1'b0);
        key_a   = 4'hF;
        start_a = 1'b0;
        tick(3);
        chk("t4_idle",      state_a, 2'b00);
        chk("t4_foul_clr",  foul_a, 4'b0000);
        chk("t4_flag_clr",  foul_flag_a, 1'b0);

        // 5: abort mid-countdown
        start_a = 1'b1;
        tick(3);
        key_a = 4'b1110;
        tick(3);
        chk("t5_answer", state_a, 2'b10);
        key_a = 4'hF;
        tick(12);
        chk("t5_tmr02", {tmr_h_a, tmr_l_a}, 8'h02);
        start_a = 1'b0;
        tick(3);
        chk("t5_idle",   state_a, 2'b00);
        chk("t5_tmr03",  {tmr_h_a, tmr_l_a}, 8'h03);
        chk("t5_id",     win_id_a, 4'd0);
        chk("t5_no_buz", buz_to_a, 1'b0);
        chk("t5_tover",  time_over_a, 1'b0);

        // 6: asynchronous reset mid-answer
        start_a = 1'b1;
        tick(3);
        key_a = 4'b1011;
        tick(3);
        chk("t6_answer", state_a, 2'b10);
        key_a = 4'hF;
        tick(12);
        chk("t6_tmr02", {tmr_h_a, tmr_l_a}, 8'h02);
        #2;
        rst_n   = 1'b0;
        start_a = 1'b0;
        #1;
        chk("t6_rst_state", state_a, 2'b00);
        chk("t6_rst_oh",    win_oh_a, 4'b0000);
        chk("t6_rst_id",    win_id_a, 4'd0);
        chk("t6_rst_tmr",   {tmr_h_a, tmr_l_a}, 8'h03);
        chk("t6_rst_buz",   {buz_ans_a, buz_to_a}, 2'b00);
        #10;
        rst_n = 1'b1;
        tick(4);
        chk("t6_post_state", state_a, 2'b00);

        // 7: 8-player instance, key7 wins, 10 -> 09 borrow
        start_b = 1'b1;
        tick(3);
        chk("t7_armed", state_b, 2'b01);
        key_b = 8'h7F;
        tick(3);
        chk("t7_state", state_b, 2'b10);
        chk("t7_id",    win_id_b, 4'd8);
        chk("t7_oh",    win_oh_b, 8'h80);
        chk("t7_buz",   buz_ans_b, 1'b1);
        key_b = 8'hFF;
        tick(9);
        chk("t7_tmr10", {tmr_h_b, tmr_l_b}, 8'h10);
        tick(1);
        chk("t7_tmr09", {tmr_h_b, tmr_l_b}, 8'h09);
        tick(10);
        chk("t7_tmr08", {tmr_h_b, tmr_l_b}, 8'h08);
        start_b = 1'b0;
        tick(3);
        chk("t7_idle",  state_b, 2'b00);
        chk("t7_reload", {tmr_h_b, tmr_l_b}, 8'h10);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
